rv_scoreboard: RTL and testbench

Register-hazard scoreboard and issue controller for the decode stage. Tracks outstanding destination-register writes from issue to writeback, and drives the decoder's `source_not_ready` so that a uop is re-dispatched until its sources are clean. Provides a drain/fence sequence that blocks issue until all in-flight writes retire. Sits between the decoder, the architectural register file write port and the pipeline control logic.

---
 rtl/rv_scoreboard.sv | 107 ++++++++++
 tb/tb_rv_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rv_scoreboard.sv
// rv_scoreboard: per-register pending-write counters for decode-stage hazard
// detection, plus a fence sequence that drains all in-flight writes.
module rv_scoreboard #(
   parameter int NUM_REGS       = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      system_stall,
   input  logic                      issue_valid,
   input  logic [REG_ADDR_WIDTH-1:0] rs1,
   input  logic [REG_ADDR_WIDTH-1:0] rs2,
   input  logic [REG_ADDR_WIDTH-1:0] rd,
   input  logic                      rs1_valid,
   input  logic                      rs2_valid,
   input  logic                      rd_valid,
   input  logic                      wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
   input  logic                      fence_req,
   output logic                      source_not_ready,
   output logic                      issue_fire,
   output logic                      issue_block,
   output logic                      fence_done,
   output logic [NUM_REGS-1:0]       busy,
   output logic                      pending_any,
   output logic                      wb_underflow
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t state_q, state_d;

   // Entry 0 is a hard zero so x0 reads as never pending.
   logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt_vec;
   logic rs1_haz, rs2_haz, rd_full;

   assign cnt_vec[0] = '0;
   assign busy[0]    = 1'b0;

   // Hazard terms read registered counts only: no writeback bypass.
   always_comb begin
      rs1_haz = rs1_valid & (rs1 != '0) & (cnt_vec[rs1] != '0);
      rs2_haz = rs2_valid & (rs2 != '0) & (cnt_vec[rs2] != '0);
      rd_full = rd_valid  & (rd  != '0) & (cnt_vec[rd] == CNT_MAX);
   end

   assign issue_block      = (state_q == DRAIN);
   assign source_not_ready = issue_valid & (rs1_haz | rs2_haz | rd_full | issue_block);
   assign issue_fire       = issue_valid & ~source_not_ready & ~system_stall & ~flush;
   assign pending_any      = |busy;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      logic [CNT_WIDTH-1:0] cnt_q;
      logic                 inc, dec;

      assign inc = issue_fire & rd_valid & (rd == REG_ADDR_WIDTH'(i));
      assign dec = wb_valid & (wb_rd == REG_ADDR_WIDTH'(i)) & (cnt_q != '0);

      // Counter: flush clears, simultaneous inc/dec cancel out.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)             cnt_q <= '0;
         else if (flush)        cnt_q <= '0;
         else if (inc && !dec)  cnt_q <= cnt_q + 1'b1;
         else if (dec && !inc)  cnt_q <= cnt_q - 1'b1;
      end

      assign cnt_vec[i] = cnt_q;
      assign busy[i]    = (cnt_q != '0);
   end

   // Sticky flag for a writeback to a register with nothing outstanding.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wb_underflow <= 1'b0;
      else if (!flush && wb_valid && (wb_rd != '0) && (cnt_vec[wb_rd] == '0))
         wb_underflow <= 1'b1;
   end

   // Fence FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Fence FSM next state; flush always returns to RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (fence_req) state_d = pending_any ? DRAIN : DONE;
         DRAIN:   if (!pending_any) state_d = DONE;
         DONE:    state_d = RUN;
         default: state_d = RUN;
      endcase
      if (flush) state_d = RUN;
   end

   // One-cycle completion pulse following the DONE state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) fence_done <= 1'b0;
      else       fence_done <= (state_q == DONE) & ~flush;
   end

endmodule

// File: tb/tb_rv_scoreboard.sv
// Directed + random bench for rv_scoreboard against a queue-free counter model.
module tb_rv_scoreboard;

   logic        clk = 1'b0;
   logic        reset, flush, system_stall, issue_valid;
   logic [4:0]  rs1, rs2, rd, wb_rd;
   logic        rs1_valid, rs2_valid, rd_valid, wb_valid, fence_req;
   logic        source_not_ready, issue_fire, issue_block, fence_done;
   logic [31:0] busy;
   logic        pending_any, wb_underflow;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: outstanding writes per register, fence progress.
   int  m_cnt [32];
   bit  m_uf;
   bit  m_draining, m_done_next, m_fd;

   always #5 clk = ~clk;

   rv_scoreboard dut (
      .clk(clk), .reset(reset), .flush(flush), .system_stall(system_stall),
      .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
      .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rd_valid(rd_valid),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .fence_req(fence_req),
      .source_not_ready(source_not_ready), .issue_fire(issue_fire),
      .issue_block(issue_block), .fence_done(fence_done), .busy(busy),
      .pending_any(pending_any), .wb_underflow(wb_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_pend();
      for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_draining = 0; m_done_next = 0; m_fd = 0;
   endtask

   task automatic uop(input bit v, input int a, input bit av, input int b, input bit bv,
                      input int d, input bit dv);
      issue_valid = v; rs1 = 5'(a); rs1_valid = av; rs2 = 5'(b); rs2_valid = bv;
      rd = 5'(d); rd_valid = dv;
   endtask

   task automatic wb(input bit v, input int r);
      wb_valid = v; wb_rd = 5'(r);
   endtask

   // Check everything at the negedge, advance the model, step past posedge.
   task automatic tick();
      logic [31:0] eb;
      bit snr, fire, pend, dec_ok;
      @(negedge clk);
      pend = m_pend();
      eb = '0;
      for (int i = 1; i < 32; i++) eb[i] = (m_cnt[i] != 0);
      snr = issue_valid && (
            (rs1_valid && rs1 != 0 && m_cnt[rs1] > 0) ||
            (rs2_valid && rs2 != 0 && m_cnt[rs2] > 0) ||
            (rd_valid  && rd  != 0 && m_cnt[rd] == 3) || m_draining);
      fire = issue_valid && !snr && !system_stall && !flush;
      chk("source_not_ready", 32'(source_not_ready), 32'(snr));
      chk("issue_fire", 32'(issue_fire), 32'(fire));
      chk("busy", busy, eb);
      chk("pending_any", 32'(pending_any), 32'(pend));
      chk("issue_block", 32'(issue_block), 32'(m_draining));
      chk("fence_done", 32'(fence_done), 32'(m_fd));
      chk("wb_underflow", 32'(wb_underflow), 32'(m_uf));
      if (flush) begin
         m_clear();
      end else begin
         dec_ok = wb_valid && wb_rd != 0 && m_cnt[wb_rd] > 0;
         if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_uf = 1;
         if (dec_ok) m_cnt[wb_rd]--;
         if (fire && rd_valid && rd != 0) m_cnt[rd]++;
         m_fd = m_done_next;
         if (m_done_next)     m_done_next = 0;
         else if (m_draining) begin
            if (!pend) begin m_draining = 0; m_done_next = 1; end
         end else if (fence_req) begin
            if (pend) m_draining = 1; else m_done_next = 1;
         end
      end
      @(posedge clk);
      #1;
      fence_req = 0;
      flush = 0;
   endtask

   initial begin
      reset = 1; flush = 0; system_stall = 0; fence_req = 0;
      uop(0, 0, 0, 0, 0, 0, 0); wb(0, 0);
      m_clear(); m_uf = 0;
      #3;
      chk("reset busy", busy, 32'h0);
      chk("reset block", 32'(issue_block), 32'h0);
      chk("reset fence_done", 32'(fence_done), 32'h0);
      chk("reset underflow", 32'(wb_underflow), 32'h0);
      #9 reset = 0;
      @(posedge clk); #1;

      // Back-to-back RAW on x5
      uop(1, 0, 0, 0, 0, 5, 1); tick();
      uop(1, 5, 1, 0, 0, 6, 1); tick();
      wb(1, 5); tick();
      wb(0, 0); tick();
      uop(0, 0, 0, 0, 0, 0, 0); wb(1, 6); tick();
      wb(0, 0);

      // x0 never tracked, no underflow on wb to x0
      uop(1, 0, 1, 0, 1, 0, 1); repeat (3) tick();
      uop(0, 0, 0, 0, 0, 0, 0); wb(1, 0); tick();
      wb(0, 0);

      // Saturation on x7
      uop(1, 0, 0, 0, 0, 7, 1); repeat (4) tick();
      wb(1, 7); tick();
      wb(0, 0); tick();
      uop(0, 0, 0, 0, 0, 0, 0); wb(1, 7); repeat (3) tick();
      wb(0, 0);

      // Same-register inc/dec, then underflow on x9
      uop(1, 0, 0, 0, 0, 3, 1); tick();
      wb(1, 3); tick();
      uop(0, 0, 0, 0, 0, 0, 0); wb(1, 9); tick();
      wb(1, 3); tick();
      wb(0, 0); tick();

      // Fence with two writes pending; decoder retries during drain
      uop(1, 0, 0, 0, 0, 4, 1); tick();
      uop(1, 0, 0, 0, 0, 8, 1); tick();
      uop(1, 1, 1, 0, 0, 0, 0); fence_req = 1; tick();
      tick();
      wb(1, 4); tick();
      wb(1, 8); tick();
      wb(0, 0); repeat (4) tick();

      // Idle fence
      uop(0, 0, 0, 0, 0, 0, 0); fence_req = 1; repeat (4) tick();

      // Flush mid-drain
      uop(1, 0, 0, 0, 0, 4, 1); tick();
      uop(1, 0, 0, 0, 0, 8, 1); tick();
      uop(0, 0, 0, 0, 0, 0, 0); fence_req = 1; tick();
      tick();
      flush = 1; tick();
      repeat (3) tick();

      // Async reset mid-drain
      uop(1, 0, 0, 0, 0, 4, 1); tick();
      uop(1, 0, 0, 0, 0, 8, 1); tick();
      uop(0, 0, 0, 0, 0, 0, 0); fence_req = 1; tick();
      tick();
      @(negedge clk); #1;
      reset = 1; #1;
      chk("async busy", busy, 32'h0);
      chk("async pending", 32'(pending_any), 32'h0);
      chk("async block", 32'(issue_block), 32'h0);
      chk("async fence_done", 32'(fence_done), 32'h0);
      chk("async underflow", 32'(wb_underflow), 32'h0);
      m_clear(); m_uf = 0;
      #1 reset = 0;
      @(posedge clk); #1;
      repeat (3) tick();

      // Random traffic on a small register window for dense hazards
      for (int n = 0; n < 600; n++) begin
         uop(($urandom % 4) != 0, $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2,
             $urandom % 8, ($urandom % 4) != 0);
         wb(($urandom % 2), $urandom % 8);
         system_stall = (($urandom % 6) == 0);
         fence_req = (($urandom % 20) == 0);
         flush = (($urandom % 60) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
